// File: rtl/serial_addsub_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_ctrl_if
// Description : Request/operand/result bundle for the bit-serial add/sub unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, A, B, sel,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, A, B, sel,
    output busy, done, result, cout, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_ctrl
// Description : Bit-serial two's complement adder/subtractor, one bit per
//               cycle LSB first through a single full-adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_ctrl #(
  parameter int WIDTH = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  serial_addsub_ctrl_if.slave bus
);

  localparam int              c_IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sel;
  logic [c_IW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic w_a_bit;
  logic w_b_bit;
  logic w_sum;
  logic w_co;

  // Subtraction is A + ~B + 1: B is inverted by sel and the carry seeds with sel.
  assign w_a_bit = r_a[r_idx];
  assign w_b_bit = r_b[r_idx] ^ r_sel;
  assign w_sum   = w_a_bit ^ w_b_bit ^ r_carry;
  assign w_co    = (w_a_bit & w_b_bit) | (r_carry & (w_a_bit ^ w_b_bit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= 1'b0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_sel    <= bus.sel;
            r_idx    <= '0;
            r_carry  <= bus.sel;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_result[r_idx] <= w_sum;
          r_carry         <= w_co;
          if (r_idx == c_LAST) begin
            // r_carry here is the carry into the MSB slice.
            r_cout  <= w_co;
            r_ovf   <= r_carry ^ w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + c_IW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub_ctrl
// Description : Scoreboard bench for serial_addsub_ctrl (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_ctrl;

  localparam int c_W = 32;

  typedef struct {
    logic [c_W-1:0] res;
    logic           cout;
    logic           ovf;
    int             cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   busy_cnt;
  int   done_cnt;
  exp_t sb[$];
  exp_t last_exp;

  serial_addsub_ctrl_if #(.WIDTH(c_W)) bus ();

  serial_addsub_ctrl #(.WIDTH(c_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic s);
    exp_t           m;
    logic [c_W:0]   full;
    logic [c_W-1:0] bx;
    bx     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bx} + (c_W+1)'(s);
    m.res  = full[c_W-1:0];
    m.cout = full[c_W];
    m.ovf  = (a[c_W-1] == bx[c_W-1]) && (full[c_W-1] != a[c_W-1]);
    m.cyc  = 0;
    return m;
  endfunction

  // Output monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        check("busy_at_done", 64'(bus.busy), 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e        = sb.pop_front();
          last_exp = e;
          check("result",      64'(bus.result),   64'(e.res));
          check("cout",        64'(bus.cout),     64'(e.cout));
          check("overflow",    64'(bus.overflow), 64'(e.ovf));
          check("done_cycle",  64'(cyc),          64'(e.cyc));
          check("busy_cycles", 64'(busy_cnt),     64'(c_W));
        end
        busy_cnt = 0;
        done_cnt++;
      end
    end
  end

  // Presents a request before the next rising edge; caller ensures DUT can accept.
  task automatic issue(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic s);
    exp_t e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.sel   = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e         = model(a, b, s);
    e.cyc     = cyc + c_W;
    sb.push_back(e);
    bus.A     = $urandom;
    bus.B     = $urandom;
    bus.sel   = ~s;
  endtask

  task automatic wait_done();
    int n;
    bit ok;
    n  = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 3 * c_W; i++) begin
      @(negedge clk);
      if (done_cnt > n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [c_W-1:0] a, input logic [c_W-1:0] b, input logic s);
    @(negedge clk);
    issue(a, b, s);
    wait_done();
  endtask

  initial begin
    int   saved;
    exp_t tmp;
    checks    = 0;
    failures  = 0;
    busy_cnt  = 0;
    done_cnt  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.sel   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     64'(bus.busy),     64'd0);
    check("rst_done",     64'(bus.done),     64'd0);
    check("rst_result",   64'(bus.result),   64'd0);
    check("rst_cout",     64'(bus.cout),     64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd5,          32'd3, 1'b0);
    run_op(32'd5,          32'd3, 1'b1);
    run_op(32'd0,          32'd1, 1'b1);
    run_op(32'h7FFF_FFFF,  32'd1, 1'b0);
    run_op(32'h8000_0000,  32'd1, 1'b1);
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, 1'(i));

    // Result holds in IDLE.
    repeat (3) @(negedge clk);
    check("hold_result", 64'(bus.result), 64'(last_exp.res));
    check("hold_busy",   64'(bus.busy),   64'd0);

    // Start re-pulsed mid-run with new operands must be ignored.
    @(negedge clk);
    issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    tmp = model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
    check("partial_low",  64'(bus.result[9:0]),        64'(tmp.res[9:0]));
    check("partial_high", 64'(bus.result[c_W-1:10]),   64'd0);
    bus.start = 1'b1;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0BAD_F00D;
    bus.sel   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_mid_run", 64'(bus.busy), 64'd1);
    wait_done();

    // Back-to-back: start held in the DONE cycle.
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3 * c_W; i++) begin
        @(negedge clk);
        #1;
        if (bus.done) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) check("b2b_first_timeout", 64'd0, 64'd1);
    end
    issue(32'h0000_0010, 32'h0000_0020, 1'b1);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done();

    // Reset at cycle 16 of RUN aborts without a done pulse.
    @(negedge clk);
    issue(32'hAAAA_5555, 32'h1111_2222, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    saved = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_busy",     64'(bus.busy),     64'd0);
    check("abort_done",     64'(bus.done),     64'd0);
    check("abort_result",   64'(bus.result),   64'd0);
    check("abort_cout",     64'(bus.cout),     64'd0);
    check("abort_overflow", 64'(bus.overflow), 64'd0);
    void'(sb.pop_back());
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("start_in_reset", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (c_W + 8) @(negedge clk);
    check("no_done_after_abort", 64'(done_cnt), 64'(saved));
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on clk rising edge.
REQ-005 A  input  WIDTH  first operand; captured when start is accepted.
REQ-006 B  input  WIDTH  second operand; captured when start is accepted.
REQ-007 sel  input  1  operation; 0 = A+B, 1 = A-B (two's complement); captured with operands.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; result, cout and overflow are valid.
REQ-010 result  output  WIDTH  sum/difference; holds until the next accepted start.
REQ-011 cout  output  1  carry out of the MSB slice.
REQ-012 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-013 Block SHALL compute the operation bit-serially through one 1-bit full-adder/subtractor slice, with B XOR sel as the slice B input, LSB first, one bit per cycle.
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE: start=1 -> RUN; latch A, B, sel; bit index=0; carry register=sel; result register cleared.
REQ-016 RUN: each edge processes bit[index]; result[index]=sum; carry register=co; index increments.
REQ-017 RUN with index=WIDTH-1: final bit processed; carry into MSB stored for overflow; -> DONE.
REQ-018 DONE: done=1 for exactly one cycle; start=1 -> RUN (back-to-back accept), else -> IDLE.
REQ-019 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH; busy high in cycles after edges k..k+WIDTH-1.
REQ-020 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; never both high.
REQ-021 start while in RUN SHALL be ignored, with no effect on latched operands, index or outputs.
REQ-022 Changes on A, B, sel after acceptance SHALL NOT affect the operation in progress.
REQ-023 result, cout, overflow SHALL hold their last values in IDLE and DONE; bits of result not yet processed read 0 during RUN.
REQ-024 Bit index counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, result=0, cout=0, overflow=0, index=0, carry=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first accepted start after release SHALL begin a fresh operation.
REQ-027 start SHALL NOT be accepted on an edge where rst_n=0.

Verification
REQ-028 WIDTH=32, A=5, B=3, sel=0, start pulse -> done after 32 busy cycles; result=0x00000008, cout=0, overflow=0.
REQ-029 A=5, B=3, sel=1 -> result=0x00000002, cout=1, overflow=0; A=0, B=1, sel=1 -> result=0xFFFFFFFF, cout=0, overflow=0.
REQ-030 A=0x7FFFFFFF, B=1, sel=0 -> result=0x80000000, cout=0, overflow=1; A=0x80000000, B=1, sel=1 -> result=0x7FFFFFFF, cout=1, overflow=1.
REQ-031 start re-pulsed and A/B changed at cycle 10 of RUN -> ignored; first result unchanged, done at the original cycle.
REQ-032 start held high in the DONE cycle with new operands -> busy reasserts the next cycle; second done exactly 33 cycles after the first.
REQ-033 rst_n pulsed low at cycle 16 of RUN -> all outputs 0 immediately, no done; a subsequent start yields the correct result.
